id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 198 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// This stage latches the decoded instruction. It selects ALU operands from the
// EX/MEM and MEM/WB results, and it inserts a bubble when a load result is not yet available.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm16,
    input  logic [14:0] id_addr,
    input  logic [12:0] id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        load_use_stall,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_is_sign,
    output logic        alu_sign_rst,
    output logic        ex_valid,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dst_addr,
    output logic [2:0]  ex_ctrl
);

    // id_ctrl field positions
    localparam int C_IS_SIGN   = 4;
    localparam int C_ALUSRC    = 5;
    localparam int C_IMM_ZEXT  = 6;
    localparam int C_SHIFT_SA  = 7;
    localparam int C_REG_DST   = 8;
    localparam int C_REG_WRITE = 9;
    localparam int C_MEM_READ  = 10;
    localparam int C_MEM_WRITE = 11;
    localparam int C_SIGN_RST  = 12;

    // Stage registers. Only the control fields that EX uses are kept.
    // imm_zext and reg_dst are resolved at capture time.
    logic        valid_q,     valid_d;
    logic [3:0]  alu_op_q,    alu_op_d;
    logic        is_sign_q,   is_sign_d;
    logic        alusrc_q,    alusrc_d;
    logic        shift_q,     shift_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        sign_rst_q,  sign_rst_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm32_q,     imm32_d;
    logic [4:0]  rs_addr_q,   rs_addr_d;
    logic [4:0]  rt_addr_q,   rt_addr_d;
    logic [4:0]  dst_q,       dst_d;

    logic        do_bubble;
    logic        do_capture;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Load in EX whose destination feeds the instruction now in ID
    always_comb begin
        load_use_stall = valid_q & mem_read_q & (dst_q != 5'd0) & id_valid &
                         ((dst_q == id_addr[14:10]) | (dst_q == id_addr[9:5]));
    end

    // Update priority: flush, then stall (hold), then load-use bubble, then capture
    always_comb begin
        do_bubble  = flush | (~stall & (load_use_stall | ~id_valid));
        do_capture = ~flush & ~stall & ~load_use_stall & id_valid;
    end

    // Next-state selection: hold by default, otherwise bubble or capture
    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        is_sign_d   = is_sign_q;
        alusrc_d    = alusrc_q;
        shift_d     = shift_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        sign_rst_d  = sign_rst_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm32_d     = imm32_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        dst_d       = dst_q;
        if (do_bubble) begin
            valid_d     = 1'b0;
            alu_op_d    = 4'd0;
            is_sign_d   = 1'b0;
            alusrc_d    = 1'b0;
            shift_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            sign_rst_d  = 1'b1;
            rs_data_d   = 32'd0;
            rt_data_d   = 32'd0;
            imm32_d     = 32'd0;
            rs_addr_d   = 5'd0;
            rt_addr_d   = 5'd0;
            dst_d       = 5'd0;
        end else if (do_capture) begin
            valid_d     = 1'b1;
            alu_op_d    = id_ctrl[3:0];
            is_sign_d   = id_ctrl[C_IS_SIGN];
            alusrc_d    = id_ctrl[C_ALUSRC];
            shift_d     = id_ctrl[C_SHIFT_SA];
            reg_write_d = id_ctrl[C_REG_WRITE];
            mem_read_d  = id_ctrl[C_MEM_READ];
            mem_write_d = id_ctrl[C_MEM_WRITE];
            sign_rst_d  = id_ctrl[C_SIGN_RST];
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm32_d     = id_ctrl[C_IMM_ZEXT] ? {16'd0, id_imm16}
                                              : {{16{id_imm16[15]}}, id_imm16};
            rs_addr_d   = id_addr[14:10];
            rt_addr_d   = id_addr[9:5];
            dst_d       = id_ctrl[C_REG_DST] ? id_addr[4:0] : id_addr[9:5];
        end
    end

    // Stage register with asynchronous reset to a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_op_q    <= 4'd0;
            is_sign_q   <= 1'b0;
            alusrc_q    <= 1'b0;
            shift_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            sign_rst_q  <= 1'b1;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm32_q     <= 32'd0;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            dst_q       <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            is_sign_q   <= is_sign_d;
            alusrc_q    <= alusrc_d;
            shift_q     <= shift_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            sign_rst_q  <= sign_rst_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm32_q     <= imm32_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            dst_q       <= dst_d;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; $0 never forwards
    always_comb begin
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs_addr_q)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs_addr_q)
            fwd_rs = memwb_result;
        else
            fwd_rs = rs_data_q;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rt_addr_q)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rt_addr_q)
            fwd_rt = memwb_result;
        else
            fwd_rt = rt_data_q;
    end

    // EX-facing outputs; shamt sits in imm bits [10:6]
    always_comb begin
        alu_a         = shift_q ? {27'd0, imm32_q[10:6]} : fwd_rs;
        alu_b         = alusrc_q ? imm32_q : fwd_rt;
        alu_op        = alu_op_q;
        alu_is_sign   = is_sign_q;
        alu_sign_rst  = sign_rst_q | ~valid_q;
        ex_valid      = valid_q;
        ex_store_data = fwd_rt;
        ex_dst_addr   = dst_q;
        ex_ctrl       = {mem_write_q, mem_read_q, reg_write_q};
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A behavioural model of the stage contents is
// checked against the DUT on every falling edge. Literal checks at each scenario pin the model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic [14:0] id_addr;
    logic [12:0] id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall, alu_is_sign, alu_sign_rst, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
        .id_addr(id_addr), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_is_sign(alu_is_sign), .alu_sign_rst(alu_sign_rst), .ex_valid(ex_valid),
        .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr), .ex_ctrl(ex_ctrl)
    );

    always #10 clk = ~clk;

    // Model: the raw instruction held in EX, as it was captured from ID
    typedef struct {
        logic        valid;
        logic [31:0] rs, rt;
        logic [15:0] imm;
        logic [14:0] addr;
        logic [12:0] ctrl;
    } stage_t;

    stage_t m;

    function automatic stage_t bubble();
        stage_t b;
        b.valid = 1'b0; b.rs = 0; b.rt = 0; b.imm = 0; b.addr = 0; b.ctrl = 13'h1000;
        return b;
    endfunction

    function automatic logic [4:0] m_dst(input stage_t s);
        return s.ctrl[8] ? s.addr[4:0] : s.addr[9:5];
    endfunction

    function automatic logic m_lus(input stage_t s);
        logic [4:0] d;
        d = m_dst(s);
        return s.valid && s.ctrl[10] && d != 0 && id_valid &&
               (d == id_addr[14:10] || d == id_addr[9:5]);
    endfunction

    function automatic logic [31:0] fwdv(input logic [4:0] a, input logic [31:0] v);
        if (a != 0 && exmem_reg_write && exmem_rd == a) return exmem_result;
        if (a != 0 && memwb_reg_write && memwb_rd == a) return memwb_result;
        return v;
    endfunction

    // Model update: same priority rules as the stage, applied to whole instructions
    always @(posedge clk or posedge rst) begin
        stage_t c;
        c.valid = 1'b1; c.rs = id_rs_data; c.rt = id_rt_data;
        c.imm = id_imm16; c.addr = id_addr; c.ctrl = id_ctrl;
        if (rst)                 m <= bubble();
        else if (flush)          m <= bubble();
        else if (stall)          m <= m;
        else if (m_lus(m))       m <= bubble();
        else if (!id_valid)      m <= bubble();
        else                     m <= c;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] frs, frt, imm32, ea, eb;
            frs   = fwdv(m.addr[14:10], m.rs);
            frt   = fwdv(m.addr[9:5], m.rt);
            imm32 = m.ctrl[6] ? {16'h0, m.imm} : {{16{m.imm[15]}}, m.imm};
            ea    = m.ctrl[7] ? {27'd0, m.imm[10:6]} : frs;
            eb    = m.ctrl[5] ? imm32 : frt;
            chk("model alu_a", alu_a, ea);
            chk("model alu_b", alu_b, eb);
            chk("model alu_op", {28'd0, alu_op}, {28'd0, m.ctrl[3:0]});
            chk("model alu_is_sign", {31'd0, alu_is_sign}, {31'd0, m.ctrl[4]});
            chk("model alu_sign_rst", {31'd0, alu_sign_rst}, {31'd0, m.ctrl[12] | ~m.valid});
            chk("model ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("model store_data", ex_store_data, frt);
            chk("model dst", {27'd0, ex_dst_addr}, {27'd0, m_dst(m)});
            chk("model ex_ctrl", {29'd0, ex_ctrl}, {29'd0, m.ctrl[11:9]});
            chk("model load_use", {31'd0, load_use_stall}, {31'd0, m_lus(m)});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [14:0] addr, input logic [12:0] ctrl);
        id_valid = v; id_rs_data = rs; id_rt_data = rt;
        id_imm16 = imm; id_addr = addr; id_ctrl = ctrl;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, " valid"}, {31'd0, ex_valid}, 32'd0);
        chk({nm, " sign_rst"}, {31'd0, alu_sign_rst}, 32'd1);
        chk({nm, " alu_a"}, alu_a, 32'd0);
        chk({nm, " alu_b"}, alu_b, 32'd0);
        chk({nm, " ex_ctrl"}, {29'd0, ex_ctrl}, 32'd0);
        chk({nm, " store"}, ex_store_data, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        set_id(1'b1, 32'h1234, 32'h5678, 16'h00FF, {5'd1, 5'd2, 5'd3}, 13'h0300);
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        step();
        cmp_en = 1'b1;
        step();
        // Reset holds a bubble even with stall/flush and a valid ID instruction
        chk_bubble("reset");
        chk("reset op", {28'd0, alu_op}, 32'd0);
        chk("reset dst", {27'd0, ex_dst_addr}, 32'd0);

        // add $3,$1,$2 with rs=5 rt=7
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'd5, 32'd7, 16'h0000, {5'd1, 5'd2, 5'd3}, 13'h0300);
        step();
        chk("add alu_a", alu_a, 32'd5);
        chk("add alu_b", alu_b, 32'd7);
        chk("add op", {28'd0, alu_op}, 32'd0);
        chk("add valid", {31'd0, ex_valid}, 32'd1);
        chk("add dst", {27'd0, ex_dst_addr}, 32'd3);
        chk("add ex_ctrl", {29'd0, ex_ctrl}, 32'b001);
        chk("add sign_rst", {31'd0, alu_sign_rst}, 32'd0);

        // Forwarding on rs=$3: EX/MEM beats MEM/WB, rd=0 never forwards
        set_id(1'b1, 32'h11, 32'h22, 16'h0000, {5'd3, 5'd2, 5'd5}, 13'h0300);
        step();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        #1 chk("fwd exmem wins", alu_a, 32'hAA);
        exmem_rd = 0;
        #1 chk("fwd memwb", alu_a, 32'hBB);
        memwb_rd = 2; memwb_result = 32'hCC;
        #1 chk("fwd rt alu_b", alu_b, 32'hCC);
        chk("fwd rt store", ex_store_data, 32'hCC);
        chk("no fwd rs", alu_a, 32'h11);
        exmem_reg_write = 0; memwb_reg_write = 0; memwb_rd = 0;

        // addi with sign- and zero-extended immediates
        set_id(1'b1, 32'd0, 32'd0, 16'hFFFF, {5'd1, 5'd9, 5'd0}, 13'h0220);
        step();
        chk("addi sext", alu_b, 32'hFFFF_FFFF);
        chk("addi dst rt", {27'd0, ex_dst_addr}, 32'd9);
        set_id(1'b1, 32'd0, 32'd0, 16'hFFFF, {5'd1, 5'd9, 5'd0}, 13'h0260);
        step();
        chk("addi zext", alu_b, 32'h0000_FFFF);
        // sll by 4 with op 5
        set_id(1'b1, 32'd77, 32'd3, 16'h0100, {5'd0, 5'd2, 5'd8}, 13'h0385);
        step();
        chk("sll alu_a", alu_a, 32'd4);
        chk("sll alu_b", alu_b, 32'd3);
        chk("sll op", {28'd0, alu_op}, 32'd5);

        // Capturing id_valid=0 yields a bubble
        set_id(1'b0, 32'd5, 32'd7, 16'h0000, {5'd1, 5'd2, 5'd3}, 13'h0300);
        step();
        chk_bubble("invalid");

        // lw $4 then add using $4: load-use bubble
        set_id(1'b1, 32'h100, 32'd0, 16'h0004, {5'd0, 5'd4, 5'd0}, 13'h0620);
        step();
        chk("lw ex_ctrl", {29'd0, ex_ctrl}, 32'b011);
        chk("lw dst", {27'd0, ex_dst_addr}, 32'd4);
        set_id(1'b1, 32'd1, 32'd2, 16'h0000, {5'd4, 5'd5, 5'd6}, 13'h0300);
        #1 chk("load_use set", {31'd0, load_use_stall}, 32'd1);
        step();
        chk_bubble("load_use");
        chk("load_use clear", {31'd0, load_use_stall}, 32'd0);
        step();
        chk("after lu valid", {31'd0, ex_valid}, 32'd1);
        chk("after lu alu_a", alu_a, 32'd1);
        chk("after lu dst", {27'd0, ex_dst_addr}, 32'd6);

        // Stall holds, stall+flush bubbles
        stall = 1'b1;
        set_id(1'b1, 32'd99, 32'd98, 16'h0000, {5'd7, 5'd8, 5'd9}, 13'h0301);
        step();
        chk("stall alu_a", alu_a, 32'd1);
        chk("stall dst", {27'd0, ex_dst_addr}, 32'd6);
        chk("stall op", {28'd0, alu_op}, 32'd0);
        flush = 1'b1;
        step();
        chk_bubble("stall+flush");

        // Store, then stall, then reset mid-stall
        stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'h40, 32'h55, 16'h0008, {5'd1, 5'd2, 5'd0}, 13'h0820);
        step();
        chk("sw ex_ctrl", {29'd0, ex_ctrl}, 32'b100);
        chk("sw store", ex_store_data, 32'h55);
        chk("sw alu_b", alu_b, 32'd8);
        stall = 1'b1;
        step();
        chk("sw held", ex_store_data, 32'h55);
        rst = 1'b1;
        #1 chk_bubble("rst mid-stall");
        step();
        rst = 1'b0; stall = 1'b0;
        set_id(1'b1, 32'd5, 32'd7, 16'h0000, {5'd1, 5'd2, 5'd3}, 13'h0300);
        step();
        chk("post rst valid", {31'd0, ex_valid}, 32'd1);
        chk("post rst alu_b", alu_b, 32'd7);
        set_id(1'b0, 32'd0, 32'd0, 16'h0000, 15'd0, 13'h0000);
        step();
        step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
